// File: rtl/dds_loader.sv
// AD9850 loader: count -> FTW, 40-bit LSB-first serial shift, FQ_UD latch; runs DDS reset/serial-entry after rst_i.
// Load takes 1 + 82*CLK_DIV clocks with busy_o high; DDS_FTW_CLAMP_EN saturates the FTW at FTW_MAX.
module dds_loader #(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [31:0] FTW_BASE = 32'd240518169,
  parameter logic [31:0] FTW_STEP = 32'd344,
  parameter logic [31:0] FTW_MAX  = 32'd1202590843
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] count_i,
  output logic        dds_rst_o,
  output logic        dds_wclk_o,
  output logic        dds_data_o,
  output logic        dds_fqud_o,
  output logic        busy_o,
  output logic [31:0] ftw_o
);

  typedef enum logic [2:0] {
    S_RST, S_INIT_W, S_INIT_F, S_IDLE, S_CALC, S_SHIFT, S_FQUD, S_GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [5:0]  cnt;
  logic        ph_b;
  logic        force_load;
  logic [15:0] last_count;
  logic [39:0] shreg;
  logic [31:0] ftw_q;
  logic [31:0] ftw_calc;
  logic        div_end;

  assign div_end = (div_cnt == DIV_LAST);

`ifdef DDS_FTW_CLAMP_EN
  logic [47:0] ftw_sum;
  assign ftw_sum  = {16'd0, FTW_BASE} + 48'(count_i) * {16'd0, FTW_STEP};
  assign ftw_calc = (ftw_sum > {16'd0, FTW_MAX}) ? FTW_MAX : ftw_sum[31:0];
`else
  // Low 32 bits of the 48-bit sum equal the 32-bit wrapped arithmetic.
  logic unused_max;
  assign unused_max = ^FTW_MAX;
  assign ftw_calc   = FTW_BASE + 32'(count_i) * FTW_STEP;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_RST;
      div_cnt    <= '0;
      cnt        <= '0;
      ph_b       <= 1'b0;
      force_load <= 1'b1;
      last_count <= '0;
      shreg      <= '0;
      ftw_q      <= '0;
      dds_rst_o  <= 1'b0;
      dds_wclk_o <= 1'b0;
      dds_data_o <= 1'b0;
      dds_fqud_o <= 1'b0;
      busy_o     <= 1'b1;
      ftw_o      <= '0;
    end else begin
      div_cnt <= div_end ? 8'd0 : div_cnt + 8'd1;
      case (state)
        S_RST: begin
          // First clock after reset raises RESET; the 4 phases count from there.
          if (!dds_rst_o) begin
            dds_rst_o <= 1'b1;
            div_cnt   <= '0;
          end else if (div_end) begin
            if (cnt == 6'd3) begin
              cnt        <= '0;
              dds_rst_o  <= 1'b0;
              dds_wclk_o <= 1'b1;
              state      <= S_INIT_W;
            end else begin
              cnt <= cnt + 6'd1;
            end
          end
        end
        S_INIT_W: if (div_end) begin
          dds_wclk_o <= 1'b0;
          dds_fqud_o <= 1'b1;
          state      <= S_INIT_F;
        end
        S_INIT_F: if (div_end) begin
          dds_fqud_o <= 1'b0;
          busy_o     <= 1'b0;
          state      <= S_IDLE;
        end
        S_IDLE: begin
          div_cnt <= '0;
          if (force_load || (count_i != last_count)) begin
            busy_o <= 1'b1;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          last_count <= count_i;
          shreg      <= {8'h00, ftw_calc};
          ftw_q      <= ftw_calc;
          dds_data_o <= ftw_calc[0];
          force_load <= 1'b0;
          cnt        <= '0;
          ph_b       <= 1'b0;
          div_cnt    <= '0;
          state      <= S_SHIFT;
        end
        S_SHIFT: if (div_end) begin
          if (!ph_b) begin
            dds_wclk_o <= 1'b1;
            ph_b       <= 1'b1;
          end else begin
            dds_wclk_o <= 1'b0;
            ph_b       <= 1'b0;
            if (cnt == 6'd39) begin
              dds_data_o <= 1'b0;
              dds_fqud_o <= 1'b1;
              ftw_o      <= ftw_q;
              state      <= S_FQUD;
            end else begin
              cnt        <= cnt + 6'd1;
              dds_data_o <= shreg[1];
              shreg      <= shreg >> 1;
            end
          end
        end
        S_FQUD: if (div_end) begin
          dds_fqud_o <= 1'b0;
          state      <= S_GAP;
        end
        S_GAP: if (div_end) begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_loader.sv
// Bench for dds_loader: table-driven loads with a serial-stream scoreboard plus init, idle, coalescing and reset sequences.
module tb_dds_loader;

  logic        clk;
  logic        rst_i, rst2;
  logic [15:0] count_i, count2;
  logic        dds_rst_o, dds_wclk_o, dds_data_o, dds_fqud_o, busy_o;
  logic        rst2_o, wclk2, data2, fqud2, busy2;
  logic [31:0] ftw_o, ftw2;

`ifdef DDS_FTW_CLAMP_EN
  localparam logic [31:0] B2 = 32'd240518169;
  localparam logic [31:0] S2 = 32'd344;
  localparam logic [31:0] M2 = 32'd240520000;
  localparam logic [15:0] C2 = 16'd100;
  localparam logic [31:0] E2 = 32'd240520000;
`else
  localparam logic [31:0] B2 = 32'hFFFFFF00;
  localparam logic [31:0] S2 = 32'd1;
  localparam logic [31:0] M2 = 32'd1202590843;
  localparam logic [15:0] C2 = 16'h0200;
  localparam logic [31:0] E2 = 32'h00000100;
`endif

  dds_loader #(.CLK_DIV(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .count_i(count_i),
    .dds_rst_o(dds_rst_o), .dds_wclk_o(dds_wclk_o), .dds_data_o(dds_data_o),
    .dds_fqud_o(dds_fqud_o), .busy_o(busy_o), .ftw_o(ftw_o)
  );

  dds_loader #(.CLK_DIV(1), .FTW_BASE(B2), .FTW_STEP(S2), .FTW_MAX(M2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .count_i(count2),
    .dds_rst_o(rst2_o), .dds_wclk_o(wclk2), .dds_data_o(data2),
    .dds_fqud_o(fqud2), .busy_o(busy2), .ftw_o(ftw2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int bitcnt = 0;
  int wclk_rises = 0;
  int fqud_rises = 0;
  int loads = 0;
  logic prev_w = 1'b0;
  logic prev_f = 1'b0;
  logic [39:0] obs;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Serial-side scoreboard: reassemble each 40-bit word and compare on FQ_UD.
  always @(negedge clk) begin
    if (rst_i) begin
      bitcnt = 0;
    end else begin
      if (dds_wclk_o === 1'b1 && prev_w === 1'b0) begin
        if (bitcnt < 40) obs[bitcnt] = dds_data_o;
        bitcnt++;
        wclk_rises++;
      end
      if (dds_fqud_o === 1'b1 && prev_f === 1'b0) begin
        fqud_rises++;
        if (bitcnt == 40) begin
          loads++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load: word 0x%0h shifted with no load pending", obs);
          end else begin
            check("serial_word", {24'd0, obs}, {32'd0, 8'h00, exp_q.pop_front()});
          end
        end else if (bitcnt != 1) begin
          check("serial_bitcount", 64'(bitcnt), 64'd40);
        end
        bitcnt = 0;
      end
    end
    prev_w = dds_wclk_o;
    prev_f = dds_fqud_o;
  end

  function automatic logic sig(input int s);
    case (s)
      0:       return dds_rst_o;
      1:       return dds_wclk_o;
      2:       return dds_fqud_o;
      default: return busy_o;
    endcase
  endfunction

  task automatic wait_lvl(input int s, input logic lvl, input int bound, input string name);
    int n = 0;
    while (sig(s) !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(sig(s)), 64'(lvl));
  endtask

  task automatic high_width(input int s, input int bound, output int w);
    w = 0;
    while (sig(s) === 1'b1 && w < bound) begin
      @(negedge clk);
      w++;
    end
  endtask

  task automatic drive_count(input logic [15:0] v);
    @(posedge clk);
    #1 count_i = v;
    @(negedge clk);
  endtask

  task automatic init_seq(input string tag);
    int w;
    wait_lvl(0, 1'b1, 10, {tag, "_rst_rise"});
    high_width(0, 50, w);
    check({tag, "_rst_width"}, 64'(w), 64'd8);
    wait_lvl(1, 1'b1, 10, {tag, "_wclk_rise"});
    high_width(1, 50, w);
    check({tag, "_wclk_width"}, 64'(w), 64'd2);
    wait_lvl(2, 1'b1, 10, {tag, "_fqud_rise"});
    high_width(2, 50, w);
    check({tag, "_fqud_width"}, 64'(w), 64'd2);
    wait_lvl(3, 1'b1, 10, {tag, "_first_load_start"});
    high_width(3, 400, w);
    check({tag, "_first_load_busy"}, 64'(w), 64'd165);
  endtask

  typedef struct {
    logic [15:0] cnt;
    logic [31:0] ftw;
  } vec_t;

  vec_t tbl[6];
  int   w_main;
  int   f0, l0, r0, bhi;

  initial begin
    tbl[0] = '{16'd1,     32'd240518513};
    tbl[1] = '{16'd100,   32'd240552569};
    tbl[2] = '{16'd101,   32'd240552913};
    tbl[3] = '{16'd65535, 32'd263062209};
    tbl[4] = '{16'd102,   32'd240553257};
    tbl[5] = '{16'd1000,  32'd240862169};

    rst_i = 1'b1; rst2 = 1'b1; count_i = 16'd0; count2 = C2;
    exp_q.push_back(32'd240518169);
    @(posedge clk);
    #1 rst_i = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    check("reset_rst_o", 64'(dds_rst_o), 64'd0);
    check("reset_wclk", 64'(dds_wclk_o), 64'd0);
    check("reset_fqud", 64'(dds_fqud_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd1);
    check("reset_ftw", 64'(ftw_o), 64'd0);

    init_seq("init");
    check("init_ftw", 64'(ftw_o), 64'd240518169);
    check("init_queue", 64'(exp_q.size()), 64'd0);

    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(tbl[i].ftw);
      drive_count(tbl[i].cnt);
      wait_lvl(3, 1'b1, 10, "load_start");
      high_width(3, 400, w_main);
      check("load_busy_width", 64'(w_main), 64'd165);
      check("load_ftw", 64'(ftw_o), 64'(tbl[i].ftw));
      check("load_queue", 64'(exp_q.size()), 64'd0);
    end

    // Constant count: the loader must stay silent.
    r0 = wclk_rises; f0 = fqud_rises; bhi = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy_o !== 1'b0) bhi++;
    end
    check("idle_wclk", 64'(wclk_rises - r0), 64'd0);
    check("idle_fqud", 64'(fqud_rises - f0), 64'd0);
    check("idle_busy", 64'(bhi), 64'd0);

    // Changes during a load coalesce into a single follow-up load of the latest value.
    l0 = loads;
    exp_q.push_back(32'd240552569);
    exp_q.push_back(32'd240553257);
    drive_count(16'd100);
    wait_lvl(3, 1'b1, 10, "coal_start");
    repeat (20) @(negedge clk);
    drive_count(16'd101);
    repeat (20) @(negedge clk);
    drive_count(16'd102);
    high_width(3, 400, w_main);
    wait_lvl(3, 1'b1, 10, "coal_second_start");
    high_width(3, 400, w_main);
    check("coal_second_width", 64'(w_main), 64'd165);
    check("coal_ftw", 64'(ftw_o), 64'd240553257);
    check("coal_loads", 64'(loads - l0), 64'd2);
    repeat (300) @(negedge clk);
    check("coal_no_extra", 64'(loads - l0), 64'd2);
    check("coal_queue", 64'(exp_q.size()), 64'd0);

    // Reset mid-shift: partial word dropped, init reruns, then a forced load.
    f0 = fqud_rises;
    exp_q.push_back(32'd240520577);
    drive_count(16'd7);
    wait_lvl(3, 1'b1, 10, "mid_start");
    repeat (60) @(negedge clk);
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("mid_reset_ftw", 64'(ftw_o), 64'd0);
    check("mid_reset_busy", 64'(busy_o), 64'd1);
    check("mid_reset_wclk", 64'(dds_wclk_o), 64'd0);
    init_seq("mid");
    check("mid_ftw", 64'(ftw_o), 64'd240520577);
    check("mid_fqud_count", 64'(fqud_rises - f0), 64'd2);
    check("mid_queue", 64'(exp_q.size()), 64'd0);

    check("dut2_ftw", 64'(ftw2), 64'(E2));
    check("dut2_busy", 64'(busy2), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
